// File: rtl/fpu_fp16_to_int_pkg.sv
// Shared types and constants for the FP16 -> signed integer converter.
//   fp16_t       : IEEE half-precision operand layout {sign, exp, frac}
//   f2i_state_t  : converter FSM states
//   fpu_flags_t  : result flags {invalid, inexact}
// Optional feature macro: FPU_ROUND_NEAREST_EN (used by fpu_rounder).
package fpu_fp16_to_int_pkg;

  localparam int FP16_EXPW  = 5;
  localparam int FP16_FRACW = 10;
  localparam int FP16_BIAS  = 15;

  // Right shifts beyond this leave mag=0, guard=0, sticky=1 regardless,
  // so the shift count is clamped here to fit the 4-bit counter.
  localparam int F2I_MAX_RSHIFT = 12;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXPW-1:0]  exp;
    logic [FP16_FRACW-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } f2i_state_t;

  typedef struct packed {
    logic invalid;
    logic inexact;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_fp16_to_int_rounder.sv
// fpu_rounder: combinational rounding and sign application.
// Ports:
//   mag_i      : unsigned integer magnitude after denormalization
//   guard_i    : first bit shifted out below the integer LSB
//   sticky_i   : OR of all bits shifted out below the guard
//   sign_i     : operand sign
//   result_o   : signed two's-complement result
//   inexact_o  : any nonzero bits were discarded
// Macro FPU_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the
// magnitude is truncated toward zero.
module fpu_rounder #(
  parameter int INT_W = 32
) (
  input  logic [INT_W-1:0] mag_i,
  input  logic             guard_i,
  input  logic             sticky_i,
  input  logic             sign_i,
  output logic [INT_W-1:0] result_o,
  output logic             inexact_o
);

  logic             inc;
  logic [INT_W-1:0] rounded;

  always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
    inc = guard_i & (sticky_i | mag_i[0]);
`else
    inc = 1'b0;
`endif
    inexact_o = guard_i | sticky_i;
    rounded   = mag_i + {{(INT_W-1){1'b0}}, inc};
    result_o  = sign_i ? ('0 - rounded) : rounded;
  end

endmodule

// File: rtl/fpu_fp16_to_int.sv
// fpu_fp16_to_int: multi-cycle FP16 -> signed INT_W-bit integer converter.
// One conversion in flight; valid/ready on both sides.
// Ports:
//   clock, reset_L       : rising-edge clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_ready == state IDLE)
//   in_fp                : FP16 operand, held by producer until accepted
//   out_valid/out_ready  : result handshake, result held until accepted
//   out_int              : signed result
//   out_flags            : {invalid, inexact}
// Optional feature macro: FPU_ROUND_NEAREST_EN (round to nearest even,
// resolved inside fpu_rounder; default build truncates toward zero).
module fpu_fp16_to_int
  import fpu_fp16_to_int_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp16_t            in_fp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic [1:0]       out_flags
);

  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [FP16_EXPW-1:0] EXP_MAX  = '1;
  // Exponent field at which e == 10, i.e. the significand is already integral.
  localparam logic [FP16_EXPW-1:0] EXP_INT0 = 5'(FP16_BIAS + FP16_FRACW);

  f2i_state_t       state_q;
  logic [INT_W-1:0] mag_q;
  logic             guard_q;
  logic             sticky_q;
  logic             sign_q;
  logic             left_q;
  logic [3:0]       cnt_q;
  logic             out_valid_q;
  logic [INT_W-1:0] out_int_q;
  fpu_flags_t       flags_q;

  // Operand classification, evaluated on the accept edge.
  logic             acc_special;
  logic             acc_zero;
  logic             acc_left;
  logic [3:0]       acc_shamt;
  logic [FP16_EXPW-1:0] rdist;

  logic [INT_W-1:0] rnd_result;
  logic             rnd_inexact;

  always_comb begin
    acc_special = (in_fp.exp == EXP_MAX);
    acc_zero    = (in_fp.exp == '0);
    acc_left    = (in_fp.exp >= EXP_INT0);
    rdist       = EXP_INT0 - in_fp.exp;
    if (acc_left) begin
      acc_shamt = 4'(in_fp.exp - EXP_INT0);
    end else if (rdist > 5'(F2I_MAX_RSHIFT)) begin
      acc_shamt = 4'(F2I_MAX_RSHIFT);
    end else begin
      acc_shamt = rdist[3:0];
    end
  end

  fpu_rounder #(.INT_W(INT_W)) u_rounder (
    .mag_i     (mag_q),
    .guard_i   (guard_q),
    .sticky_i  (sticky_q),
    .sign_i    (sign_q),
    .result_o  (rnd_result),
    .inexact_o (rnd_inexact)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      left_q      <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      flags_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_fp.sign;
            if (acc_special) begin
              // -Inf saturates negative; +Inf and any NaN saturate positive.
              out_int_q   <= (in_fp.frac == '0 && in_fp.sign) ? MIN_NEG : MAX_POS;
              flags_q     <= '{invalid: 1'b1, inexact: 1'b0};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (acc_zero) begin
              out_int_q   <= '0;
              flags_q     <= '{invalid: 1'b0, inexact: (in_fp.frac != '0)};
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              mag_q    <= {{(INT_W-FP16_FRACW-1){1'b0}}, 1'b1, in_fp.frac};
              guard_q  <= 1'b0;
              sticky_q <= 1'b0;
              left_q   <= acc_left;
              cnt_q    <= acc_shamt;
              state_q  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            if (left_q) begin
              mag_q <= mag_q << 1;
            end else begin
              mag_q    <= mag_q >> 1;
              guard_q  <= mag_q[0];
              sticky_q <= sticky_q | guard_q;
            end
            cnt_q <= cnt_q - 4'd1;
          end
          // Leave on the last shift; a zero count still spends one cycle here.
          if (cnt_q <= 4'd1) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          out_int_q   <= rnd_result;
          flags_q     <= '{invalid: 1'b0, inexact: rnd_inexact};
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
module tb_fpu_fp16_to_int;

  localparam int INT_W = 32;

  logic             clock = 1'b0;
  logic             reset_L = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_fp = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [INT_W-1:0] out_int;
  logic [1:0]       out_flags;

  int checks = 0;
  int errors = 0;

  fpu_fp16_to_int #(.INT_W(INT_W)) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fp     (in_fp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_flags (out_flags)
  );

  always #5 clock = ~clock;

  // Reference: value = (1024+frac) * 2^(exp-25), rounded by quotient/remainder.
  task automatic model(input logic [15:0] fp, output logic [INT_W-1:0] v,
                       output logic [1:0] f, output int lat);
    logic       s;
    int         ex, fr, e, k, shamt;
    longint     sig, q, rem, half;
    logic [INT_W-1:0] maxpos, minneg;
    s  = fp[15];
    ex = int'(fp[14:10]);
    fr = int'(fp[9:0]);
    maxpos = '1; maxpos[INT_W-1] = 1'b0;
    minneg = '0; minneg[INT_W-1] = 1'b1;
    if (ex == 31) begin
      v = (fr == 0 && s) ? minneg : maxpos;
      f = 2'b10;
      lat = 1;
    end else if (ex == 0) begin
      v = '0;
      f = {1'b0, fr != 0};
      lat = 1;
    end else begin
      sig = 1024 + fr;
      e = ex - 15;
      if (e >= 10) begin
        q = sig << (e - 10);
        f = 2'b00;
        shamt = e - 10;
      end else begin
        k = 10 - e;
        q = sig >> k;
        rem = sig - (q << k);
        half = longint'(1) << (k - 1);
        f = {1'b0, rem != 0};
`ifdef FPU_ROUND_NEAREST_EN
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
`endif
        shamt = (k > 12) ? 12 : k;
      end
      lat = ((shamt < 1) ? 1 : shamt) + 2;
      v = INT_W'(s ? -q : q);
    end
  endtask

  // Drives one transaction; reports result, latency and handshake observations.
  task automatic convert(input logic [15:0] fp, output logic [INT_W-1:0] r,
                         output logic [1:0] f, output int lat, output bit timeout,
                         output bit busy_ok, output bit ready_after);
    int w;
    w = 0;
    timeout = 1'b0;
    while (!in_ready && w < 50) begin
      @(posedge clock); #1; w++;
    end
    if (!in_ready) timeout = 1'b1;
    in_fp = fp;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_fp = 16'($urandom);
    busy_ok = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clock); #1; lat++;
    end
    if (!out_valid) timeout = 1'b1;
    if (in_ready) busy_ok = 1'b0;
    r = out_int;
    f = out_flags;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    ready_after = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_int !== '0) begin errors++; $display("FAIL reset_out_int got %h want 0", out_int); end
    checks++; if (out_flags !== 2'b00) begin errors++; $display("FAIL reset_out_flags got %b want 00", out_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clock); #1;
    reset_L = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [15:0]      fps [9];
    logic [INT_W-1:0] vals [9];
    logic [1:0]       flg [9];
    int               lats [9];
    logic [INT_W-1:0] r;
    logic [1:0]       f;
    int               lat;
    bit               to, busy_ok, rdy;
    fps = '{16'h3C00, 16'h4100, 16'h4300, 16'hFBFF, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8000};
`ifdef FPU_ROUND_NEAREST_EN
    vals = '{32'd1, 32'd2, 32'd4, 32'hFFFF0020, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0};
`else
    vals = '{32'd1, 32'd2, 32'd3, 32'hFFFF0020, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0};
`endif
    flg  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    lats = '{12, 11, 11, 7, 1, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      convert(fps[i], r, f, lat, to, busy_ok, rdy);
      checks++; if (to) begin errors++; $display("FAIL dir_timeout fp=%h got timeout want none", fps[i]); end
      checks++; if (r !== vals[i]) begin errors++; $display("FAIL dir_value fp=%h got %h want %h", fps[i], r, vals[i]); end
      checks++; if (f !== flg[i]) begin errors++; $display("FAIL dir_flags fp=%h got %b want %b", fps[i], f, flg[i]); end
      checks++; if (lat != lats[i]) begin errors++; $display("FAIL dir_latency fp=%h got %0d want %0d", fps[i], lat, lats[i]); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL dir_in_ready_busy fp=%h got 1 want 0", fps[i]); end
      checks++; if (!rdy) begin errors++; $display("FAIL dir_ready_after fp=%h got 0 want 1", fps[i]); end
    end
  endtask

  task automatic test_backpressure();
    int w;
    in_fp = 16'h4B00;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(posedge clock); #1; w++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_int !== 32'd14) begin errors++; $display("FAIL bp_value cyc=%0d got %h want %h", i, out_int, 32'd14); end
      checks++; if (out_flags !== 2'b00) begin errors++; $display("FAIL bp_flags cyc=%0d got %b want 00", i, out_flags); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, in_ready); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    logic [INT_W-1:0] r;
    logic [1:0]       f;
    int               lat;
    bit               to, busy_ok, rdy;
    in_fp = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", in_ready); end
    reset_L = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    #2;
    reset_L = 1'b1;
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_stale_valid got %b want 0", out_valid); end
    convert(16'h3800, r, f, lat, to, busy_ok, rdy);
    checks++; if (to) begin errors++; $display("FAIL rst_half_timeout got timeout want none"); end
    checks++; if (r !== '0) begin errors++; $display("FAIL rst_half_value got %h want 0", r); end
    checks++; if (f !== 2'b01) begin errors++; $display("FAIL rst_half_flags got %b want 01", f); end
    checks++; if (lat != 13) begin errors++; $display("FAIL rst_half_latency got %0d want 13", lat); end
  endtask

  task automatic test_random();
    logic [15:0]      fp;
    logic [INT_W-1:0] r, ev;
    logic [1:0]       f, ef;
    int               lat, el;
    bit               to, busy_ok, rdy;
    for (int i = 0; i < 80; i++) begin
      fp = 16'($urandom);
      model(fp, ev, ef, el);
      convert(fp, r, f, lat, to, busy_ok, rdy);
      checks++; if (to) begin errors++; $display("FAIL rnd_timeout fp=%h got timeout want none", fp); end
      checks++; if (r !== ev) begin errors++; $display("FAIL rnd_value fp=%h got %h want %h", fp, r, ev); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rnd_flags fp=%h got %b want %b", fp, f, ef); end
      checks++; if (lat != el) begin errors++; $display("FAIL rnd_latency fp=%h got %0d want %0d", fp, lat, el); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL rnd_in_ready_busy fp=%h got 1 want 0", fp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0]      fp;
    logic [INT_W-1:0] r, ev;
    logic [1:0]       f, ef;
    int               lat, el;
    bit               to, busy_ok, rdy;
    for (int i = 0; i < 6; i++) begin
      // Normal operands near the integer boundary, alternating sign.
      fp = {i[0], 5'($urandom_range(14, 30)), 10'($urandom)};
      model(fp, ev, ef, el);
      convert(fp, r, f, lat, to, busy_ok, rdy);
      checks++; if (r !== ev || f !== ef) begin errors++; $display("FAIL b2b_result fp=%h got %h/%b want %h/%b", fp, r, f, ev, ef); end
      checks++; if (!rdy || to) begin errors++; $display("FAIL b2b_ready_after fp=%h got ready=%b timeout=%b want ready=1 timeout=0", fp, rdy, to); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
